// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - one SRAM-like request/response channel
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - fetch/data arbiter onto one SRAM-like port with in-order response routing
module sram_like_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  mem,
    output logic                 arb_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             hold_src_q, hold_src_d;
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             arb_err_q, arb_err_d;

    logic sel;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // During reset the registered state is ignored so mem_req follows the inputs as if idle and empty.
    always_comb begin
        full  = !reset && (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        if (!reset && state_q == S_HOLD) begin
            sel     = hold_src_q;
            mem.req = 1'b1;
        end else begin
            sel     = data.req;
            mem.req = !full && (data.req || inst.req);
        end

        mem.wr    = sel ? data.wr    : inst.wr;
        mem.size  = sel ? data.size  : inst.size;
        mem.addr  = sel ? data.addr  : inst.addr;
        mem.wstrb = sel ? data.wstrb : inst.wstrb;
        mem.wdata = sel ? data.wdata : inst.wdata;

        push = !reset && mem.req && mem.addr_ok;
        pop  = !reset && mem.data_ok && !empty;
        head = tag_q[rd_ptr_q];

        inst.addr_ok = push && !sel;
        data.addr_ok = push && sel;
        inst.data_ok = pop && !head;
        data.data_ok = pop && head;
        inst.rdata   = mem.rdata;
        data.rdata   = mem.rdata;
        arb_err      = arb_err_q;
    end

    always_comb begin
        state_d    = state_q;
        hold_src_d = hold_src_q;
        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        arb_err_d  = arb_err_q | (mem.data_ok && empty);

        if (push) begin
            tag_d[wr_ptr_q] = sel;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (state_q == S_IDLE) begin
            if (mem.req && !mem.addr_ok) begin
                state_d    = S_HOLD;
                hold_src_d = sel;
            end
        end else if (mem.addr_ok) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_src_q <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_src_q <= hold_src_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            arb_err_q  <= arb_err_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - randomized check of sram_like_arbiter against a transaction-level model
module tb_sram_like_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    logic arb_err;

    sram_like_arbiter_if inst_bus ();
    sram_like_arbiter_if data_bus ();
    sram_like_arbiter_if mem_bus ();

    sram_like_arbiter #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (inst_bus),
        .data    (data_bus),
        .mem     (mem_bus),
        .arb_err (arb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Model: outstanding owners in issue order, the stuck (offered but unaccepted) source, sticky error.
    int          owners[$];
    int          stuck_src = -1;
    bit          err_m = 1'b0;

    bit          ip, dp;
    logic [31:0] ia, da, dwd, rd;
    bit          dwr;

    initial begin
        ip = 0; dp = 0; ia = 0; da = 0; dwd = 0; dwr = 0; rd = 0;
        reset = 1'b1;
        inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2; inst_bus.addr = 0;
        inst_bus.wstrb = 4'hf; inst_bus.wdata = 0;
        data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.addr = 0;
        data_bus.wstrb = 4'hf; data_bus.wdata = 0;
        mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            int  e_src, owner;
            bit  e_req, acc, e_iok, e_dok, stray;

            @(posedge clk);
            #1;
            reset = (cyc < 2) || ($urandom_range(0, 99) == 0);
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1;
                ia = (cyc < 40) ? 32'hBFC0_0000 + 32'(cyc * 4) : $urandom;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp  = 1;
                da  = $urandom;
                dwr = $urandom_range(0, 1);
                dwd = $urandom;
            end
            inst_bus.req   = ip;
            inst_bus.addr  = ia;
            data_bus.req   = dp;
            data_bus.addr  = da;
            data_bus.wr    = dwr;
            data_bus.wdata = dwd;
            rd = $urandom;
            mem_bus.rdata   = rd;
            mem_bus.addr_ok = $urandom_range(0, 1);
            mem_bus.data_ok = (owners.size() > 0) ? ($urandom_range(0, 1) == 1)
                                                  : ($urandom_range(0, 29) == 0);

            @(negedge clk);
            if (reset) begin
                e_req = ip || dp;
                e_src = dp ? 1 : 0;
            end else if (stuck_src >= 0) begin
                e_req = 1;
                e_src = stuck_src;
            end else if (owners.size() == DEPTH) begin
                e_req = 0;
                e_src = 0;
            end else begin
                e_req = ip || dp;
                e_src = dp ? 1 : 0;
            end
            acc = !reset && e_req && mem_bus.addr_ok;

            check("mem_req", mem_bus.req, e_req);
            if (e_req) begin
                check("mem_addr", mem_bus.addr, (e_src == 1) ? da : ia);
                check("mem_wr", mem_bus.wr, (e_src == 1) ? dwr : 1'b0);
                if (e_src == 1) check("mem_wdata", mem_bus.wdata, dwd);
            end
            check("inst_addr_ok", inst_bus.addr_ok, acc && e_src == 0);
            check("data_addr_ok", data_bus.addr_ok, acc && e_src == 1);

            e_iok = 0; e_dok = 0; stray = 0;
            if (!reset && mem_bus.data_ok) begin
                if (owners.size() > 0) begin
                    owner = owners.pop_front();
                    if (owner == 0) e_iok = 1; else e_dok = 1;
                end else begin
                    stray = 1;
                end
            end
            check("inst_data_ok", inst_bus.data_ok, e_iok);
            check("data_data_ok", data_bus.data_ok, e_dok);
            if (e_iok) check("inst_rdata", inst_bus.rdata, rd);
            if (e_dok) check("data_rdata", data_bus.rdata, rd);
            check("arb_err", arb_err, err_m);

            if (reset) begin
                owners.delete();
                stuck_src = -1;
                err_m     = 0;
            end else begin
                if (acc) owners.push_back(e_src);
                stuck_src = (e_req && !acc) ? e_src : -1;
                err_m     = err_m || stray;
            end
            if (acc && e_src == 0) ip = 0;
            if (acc && e_src == 1) dp = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX issue / MEM collect). Grants one address handshake per cycle and holds the granted source stable until the downstream accepts it. Records each accepted transaction's source in an in-order tag FIFO, then routes each downstream data_ok/rdata back to its owner. Sits between the CPU pipeline and the cache/AXI bridge.

Parameters:
DEPTH, 2, max outstanding accepted-but-unanswered transactions (power of 2, >=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  IF request valid
inst_wr  in  1  IF write flag (always 0 in practice; passed through)
inst_size  in  2  IF size (0=byte, 1=half, 2=word)
inst_addr  in  32  IF address
inst_wstrb  in  4  IF byte strobe
inst_wdata  in  32  IF write data
inst_addr_ok  out  1  IF request accepted this cycle
inst_data_ok  out  1  IF response valid this cycle
inst_rdata  out  32  IF read data
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data requester, same meaning as inst_*
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data read data
mem_req  out  1  downstream request
mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/2/32/4/32  muxed request fields
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream response
mem_rdata  in  32  downstream read data
arb_err  out  1  sticky protocol error flag

Behaviour:
- Handshake: a transfer occurs on mem_req && mem_addr_ok. Requesters hold req and fields stable until their addr_ok.
- States: IDLE, HOLD. hold_src register (0=inst, 1=data).
- IDLE: if count==DEPTH, mem_req=0. Otherwise, select data if data_req, else inst if inst_req (fixed data priority). mem_req=selected req. If mem_req && !mem_addr_ok, latch hold_src=selected and go to HOLD.
- HOLD: select hold_src regardless of other requests; mem_req=1 (if count reaches DEPTH only through a pop, remain asserted; count cannot grow in HOLD). On mem_addr_ok, return to IDLE.
- Request fields and mem_req are combinational from the selected source. The unselected source's addr_ok=0.
- inst_addr_ok = mem_addr_ok && mem_req && sel==inst; data_addr_ok likewise.
- Tag FIFO, DEPTH entries: push sel on transfer. Pop head on mem_data_ok when count>0.
- inst_data_ok = mem_data_ok && count>0 && head==inst; data_data_ok likewise.
- inst_rdata = data_rdata = mem_rdata (broadcast, qualified by data_ok).
- Simultaneous push and pop: count unchanged, both pointers advance. The full check uses registered count only: no bypass when full and data_ok arrive together, so mem_req=0 that cycle.
- Pointer wrap: log2(DEPTH) bits, natural wrap. count has log2(DEPTH)+1 bits.
- mem_data_ok with count==0: no data_ok to either requester, no pop, arb_err<=1. arb_err clears only on reset.
- Reset (including mid-transaction): state=IDLE, count=0, pointers=0, hold_src=0, arb_err=0. All addr_ok/data_ok outputs are 0 that cycle and mem_req depends only on inputs (count=0). Pending downstream responses after reset raise arb_err (the bridge is reset together with this block).
- Latency: zero-cycle combinational request path; response routing is combinational from mem_data_ok.

Test Plan:
- Single fetch: inst_req=1, addr=0xBFC00000, mem_addr_ok=1 same cycle -> inst_addr_ok=1, mem_addr=0xBFC00000. Two cycles later mem_data_ok=1, rdata=0x3C080001 -> inst_data_ok=1, inst_rdata=0x3C080001, count returns to 0.
- Conflict: inst_req and data_req both 1 with data addr 0x80001000, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0. Next cycle inst is granted.
- Hold: inst_req alone with mem_addr_ok=0 for 3 cycles; data_req rises in cycle 2 -> mem_addr stays the inst address until accepted in cycle 4, then data is granted.
- Full: DEPTH=2, two transfers accepted with no response -> mem_req=0 while both requesters are asserted. mem_data_ok in the same cycle -> mem_req still 0, asserted next cycle.
- Ordering: accept inst, data, then responses R1, R2 -> inst_data_ok with R1, then data_data_ok with R2. A push concurrent with the second pop keeps count=1.
- Error/reset: mem_data_ok with count=0 -> no data_ok, arb_err=1. Reset with 2 outstanding -> count=0, arb_err=0, state IDLE.
